// File: rtl/cam_arb_pkg.sv
// Shared types and constants for the frame-buffer read arbiter.
package cam_arb_pkg;

  // Pixel width of the frame buffer (RGB565).
  localparam int PIXEL_W = 16;

  // Width of the stale-read statistics counter.
  localparam int STAT_W = 16;

  // Width of the filter wait counter; large enough for any MAX_WAIT up to 255.
  localparam int WAIT_W = 8;

  // Owner of the single frame-buffer read port in a given cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_FLT  = 2'd2
  } owner_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fb_read_cache.sv
// One-entry display pixel cache: hit compare, fill tracking and line-end invalidate.
// A fill starts in the cycle the display owns the memory port; the returned
// pixel arrives one cycle later and is captured on the edge that ends that cycle.
module fb_read_cache
  import cam_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = PIXEL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  hit,
  output logic                  fill_pend,
  output logic [DATA_WIDTH-1:0] cache_data
);

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  pend_q,  pend_d;

  // Tag compare; an invalid entry never hits.
  always_comb begin
    hit = vga_req & valid_q & (vga_addr == addr_q);
  end

  // Next-state for the entry: tag on fill start, data one cycle later,
  // and a gap in display requests (end of line) drops the entry.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pend_d  = fill_start;
    if (fill_start) begin
      addr_d  = vga_addr;
      valid_d = 1'b1;
    end
    if (!vga_req) begin
      valid_d = 1'b0;
    end
    if (pend_q) begin
      data_d = fill_data;
    end
  end

  // Cache entry registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  assign fill_pend  = pend_q;
  assign cache_data = data_q;

endmodule

// File: rtl/fb_read_arbiter.sv
// Frame-buffer read arbiter: shares one synchronous read port between the
// display reader (latency-critical, cached) and an image filter (may wait,
// but is force-granted after MAX_WAIT cycles of starvation).
module fb_read_arbiter
  import cam_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = PIXEL_W,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  input  logic                  flt_req,
  input  logic [ADDR_WIDTH-1:0] flt_addr,
  output logic                  flt_gnt,
  output logic                  flt_rvalid,
  output logic [DATA_WIDTH-1:0] flt_rdata,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [STAT_W-1:0]     vga_stale_cnt
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  owner_e                owner;
  logic                  vga_hit;
  logic                  vga_miss;
  logic                  forced;
  logic                  vga_fill_pend;
  logic [DATA_WIDTH-1:0] cache_data;

  logic [WAIT_W-1:0]     wait_cnt_q,   wait_cnt_d;
  logic [STAT_W-1:0]     stale_cnt_q,  stale_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic                  flt_rvalid_q, flt_rvalid_d;

  fb_read_cache #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cache (
    .clk        (clk),
    .reset      (reset),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .fill_start (owner == OWN_VGA),
    .fill_data  (mem_rdata),
    .hit        (vga_hit),
    .fill_pend  (vga_fill_pend),
    .cache_data (cache_data)
  );

  // Port ownership: a starved filter beats a display miss, a display miss
  // beats a normal filter request; nothing is granted while in reset.
  always_comb begin
    vga_miss = vga_req & ~vga_hit;
    forced   = flt_req & (wait_cnt_q == MAX_WAIT_C);
    owner    = OWN_NONE;
    if (!reset) begin
      owner = OWN_NONE;
    end else if (forced) begin
      owner = OWN_FLT;
    end else if (vga_miss) begin
      owner = OWN_VGA;
    end else if (flt_req) begin
      owner = OWN_FLT;
    end
  end

  // Memory port and grant outputs; the address holds when the port is idle.
  always_comb begin
    mem_en   = (owner != OWN_NONE);
    flt_gnt  = (owner == OWN_FLT);
    mem_addr = mem_addr_q;
    case (owner)
      OWN_VGA: mem_addr = vga_addr;
      OWN_FLT: mem_addr = flt_addr;
      default: mem_addr = mem_addr_q;
    endcase
  end

  // Next-state for wait counter, stale statistics and read-return tracking.
  always_comb begin
    mem_addr_d   = mem_addr;
    flt_rvalid_d = flt_gnt;
    wait_cnt_d   = wait_cnt_q;
    stale_cnt_d  = stale_cnt_q;
    if (!flt_req || flt_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    // The display missed but lost the port: it is served the cached pixel.
    if (forced && vga_miss) begin
      stale_cnt_d = sat_inc(stale_cnt_q);
    end
  end

  // Arbiter state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q   <= '0;
      stale_cnt_q  <= '0;
      mem_addr_q   <= '0;
      flt_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      stale_cnt_q  <= stale_cnt_d;
      mem_addr_q   <= mem_addr_d;
      flt_rvalid_q <= flt_rvalid_d;
    end
  end

  // Read-data steering: whoever owned the port last cycle sees memory data;
  // the display otherwise sees the cached pixel.
  always_comb begin
    vga_rdata = vga_fill_pend ? mem_rdata : cache_data;
    flt_rdata = flt_rvalid_q ? mem_rdata : '0;
  end

  assign flt_rvalid    = flt_rvalid_q;
  assign vga_stale_cnt = stale_cnt_q;

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter: a vector table for the per-cycle
// behaviour plus hand-written sequences for starvation, saturation and reset.
module tb_fb_read_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          flt_req;
  logic [AW-1:0] flt_addr;
  logic          flt_gnt;
  logic          flt_rvalid;
  logic [DW-1:0] flt_rdata;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   vga_stale_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fb_read_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_WAIT   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .vga_rdata     (vga_rdata),
    .flt_req       (flt_req),
    .flt_addr      (flt_addr),
    .flt_gnt       (flt_gnt),
    .flt_rvalid    (flt_rvalid),
    .flt_rdata     (flt_rdata),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .vga_stale_cnt (vga_stale_cnt)
  );

  always #5 clk = ~clk;

  // Frame-buffer content is a fixed function of the address.
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return 16'(a) * 16'd37 + 16'h0101;
  endfunction

  // Synchronous read memory with one cycle of latency.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= memf(mem_addr);
  end

  typedef struct {
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic          freq;
    logic [AW-1:0] faddr;
    logic          e_men;
    logic [AW-1:0] e_maddr;
    logic          e_gnt;
    logic          e_rv;
    logic [AW-1:0] e_fsrc;   // address whose pixel flt_rdata must carry
    logic          chk_v;
    logic [AW-1:0] e_vsrc;   // address whose pixel vga_rdata must carry
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input int vr, input int va, input int fr, input int fa,
                              input int men, input int ma, input int g, input int rv,
                              input int fs, input int cv, input int vs);
    vec_t v;
    v.vreq = 1'(vr);  v.vaddr = AW'(va); v.freq = 1'(fr);  v.faddr = AW'(fa);
    v.e_men = 1'(men); v.e_maddr = AW'(ma); v.e_gnt = 1'(g); v.e_rv = 1'(rv);
    v.e_fsrc = AW'(fs); v.chk_v = 1'(cv); v.e_vsrc = AW'(vs);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: inputs change just after the edge, outputs sampled mid-cycle.
  task automatic drive(input logic vr, input logic [AW-1:0] va,
                       input logic fr, input logic [AW-1:0] fa);
    @(posedge clk);
    #1;
    vga_req = vr; vga_addr = va; flt_req = fr; flt_addr = fa;
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_en"},     32'(mem_en),        32'd0);
    chk({tag, " mem_addr"},   32'(mem_addr),      32'd0);
    chk({tag, " flt_gnt"},    32'(flt_gnt),       32'd0);
    chk({tag, " flt_rvalid"}, 32'(flt_rvalid),    32'd0);
    chk({tag, " flt_rdata"},  32'(flt_rdata),     32'd0);
    chk({tag, " vga_rdata"},  32'(vga_rdata),     32'd0);
    chk({tag, " stale_cnt"},  32'(vga_stale_cnt), 32'd0);
  endtask

  logic [AW-1:0] addr_run;

  initial begin
    // Display reads with hits/misses, no filter.
    vecs[0]  = mk(1,   5, 0,   0, 1,   5, 0, 0,   0, 0,  0);
    vecs[1]  = mk(1,   5, 0,   0, 0,   5, 0, 0,   0, 1,  5);
    vecs[2]  = mk(1,   6, 0,   0, 1,   6, 0, 0,   0, 1,  5);
    vecs[3]  = mk(1,   6, 0,   0, 0,   6, 0, 0,   0, 1,  6);
    vecs[4]  = mk(0,   0, 0,   0, 0,   6, 0, 0,   0, 1,  6);
    // Same pattern with a filter slipping into the hit cycles.
    vecs[5]  = mk(1,   5, 1, 100, 1,   5, 0, 0,   0, 0,  0);
    vecs[6]  = mk(1,   5, 1, 100, 1, 100, 1, 0,   0, 1,  5);
    vecs[7]  = mk(1,   6, 1, 100, 1,   6, 0, 1, 100, 1,  5);
    vecs[8]  = mk(1,   6, 1, 100, 1, 100, 1, 0,   0, 1,  6);
    vecs[9]  = mk(0,   0, 0,   0, 0, 100, 0, 1, 100, 1,  6);
    // Line gap invalidates the cache; idle-port filter grant.
    vecs[10] = mk(1,   9, 0,   0, 1,   9, 0, 0,   0, 0,  0);
    vecs[11] = mk(1,   9, 0,   0, 0,   9, 0, 0,   0, 1,  9);
    vecs[12] = mk(0,   0, 0,   0, 0,   9, 0, 0,   0, 1,  9);
    vecs[13] = mk(1,   9, 0,   0, 1,   9, 0, 0,   0, 0,  0);
    vecs[14] = mk(1,   9, 0,   0, 0,   9, 0, 0,   0, 1,  9);
    vecs[15] = mk(0,   0, 1, 200, 1, 200, 1, 0,   0, 1,  9);
    vecs[16] = mk(0,   0, 0,   0, 0, 200, 0, 1, 200, 0,  0);
    // Filter request withdrawn before it was granted.
    vecs[17] = mk(1,  20, 1, 300, 1,  20, 0, 0,   0, 0,  0);
    vecs[18] = mk(1,  21, 0, 300, 1,  21, 0, 0,   0, 1, 20);
    vecs[19] = mk(0,   0, 0,   0, 0,  21, 0, 0,   0, 1, 21);

    // Reset with requests active: everything must read zero.
    reset = 1'b0; vga_req = 1'b1; vga_addr = 15'd3; flt_req = 1'b1; flt_addr = 15'd4;
    #12;
    chk_all_zero("reset");
    $display("reset: outputs sampled with requests active");
    @(negedge clk);
    vga_req = 1'b0; flt_req = 1'b0; vga_addr = '0; flt_addr = '0;
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].vreq, vecs[i].vaddr, vecs[i].freq, vecs[i].faddr);
      chk($sformatf("v%0d mem_en", i),     32'(mem_en),     32'(vecs[i].e_men));
      chk($sformatf("v%0d mem_addr", i),   32'(mem_addr),   32'(vecs[i].e_maddr));
      chk($sformatf("v%0d flt_gnt", i),    32'(flt_gnt),    32'(vecs[i].e_gnt));
      chk($sformatf("v%0d flt_rvalid", i), 32'(flt_rvalid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv)
        chk($sformatf("v%0d flt_rdata", i), 32'(flt_rdata), 32'(memf(vecs[i].e_fsrc)));
      if (vecs[i].chk_v)
        chk($sformatf("v%0d vga_rdata", i), 32'(vga_rdata), 32'(memf(vecs[i].e_vsrc)));
      $display("vec %0d: vreq=%0d va=%0d freq=%0d fa=%0d -> mem_en=%0d mem_addr=%0d gnt=%0d rvalid=%0d vga_rdata=0x%h",
               i, vecs[i].vreq, vecs[i].vaddr, vecs[i].freq, vecs[i].faddr,
               mem_en, mem_addr, flt_gnt, flt_rvalid, vga_rdata);
    end

    // Display misses every cycle: the filter is forced in after 8 waits.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, AW'(1000 + k), 1'b1, 15'd50);
      if (k < 8) begin
        chk($sformatf("starve%0d flt_gnt", k), 32'(flt_gnt), 32'd0);
        chk($sformatf("starve%0d mem_addr", k), 32'(mem_addr), 32'(1000 + k));
      end else if (k == 8) begin
        chk("forced flt_gnt", 32'(flt_gnt), 32'd1);
        chk("forced mem_addr", 32'(mem_addr), 32'd50);
        chk("forced stale_pre", 32'(vga_stale_cnt), 32'd0);
        chk("forced vga_rdata", 32'(vga_rdata), 32'(memf(15'd1007)));
      end else begin
        chk("stale vga_rdata", 32'(vga_rdata), 32'(memf(15'd1007)));
        chk("stale flt_rvalid", 32'(flt_rvalid), 32'd1);
        chk("stale flt_rdata", 32'(flt_rdata), 32'(memf(15'd50)));
        chk("stale cnt", 32'(vga_stale_cnt), 32'd1);
        chk("stale flt_gnt", 32'(flt_gnt), 32'd0);
      end
      $display("starve %0d: gnt=%0d mem_addr=%0d stale_cnt=%0d", k, flt_gnt, mem_addr, vga_stale_cnt);
    end

    // Saturation: preload the counter near the top, then run real stale events.
    #1;
    force dut.stale_cnt_q = 16'hFFFD;
    #1;
    release dut.stale_cnt_q;
    addr_run = 15'd2000;
    drive(1'b1, addr_run, 1'b0, 15'd60);
    addr_run = addr_run + 15'd1;
    chk("sat preload", 32'(vga_stale_cnt), 32'h0000_FFFD);
    for (int e = 0; e < 3; e++) begin
      for (int j = 0; j < 9; j++) begin
        drive(1'b1, addr_run, 1'b1, 15'd60);
        addr_run = addr_run + 15'd1;
        if (j == 8) chk($sformatf("sat%0d forced gnt", e), 32'(flt_gnt), 32'd1);
      end
      drive(1'b1, addr_run, 1'b0, 15'd60);
      addr_run = addr_run + 15'd1;
      chk($sformatf("sat%0d cnt", e), 32'(vga_stale_cnt), (e == 0) ? 32'h0000_FFFE : 32'h0000_FFFF);
      $display("sat event %0d: stale_cnt=0x%h", e, vga_stale_cnt);
    end

    // Reset arriving while a filter read is in flight.
    drive(1'b0, 15'd0, 1'b1, 15'd77);
    chk("inflight gnt", 32'(flt_gnt), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("async");
    $display("async reset: gnt=%0d mem_en=%0d stale_cnt=%0d", flt_gnt, mem_en, vga_stale_cnt);
    @(posedge clk);
    @(negedge clk);
    flt_req = 1'b0;
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      drive(1'b0, 15'd0, 1'b0, 15'd0);
      chk($sformatf("post_reset%0d flt_rvalid", r), 32'(flt_rvalid), 32'd0);
      $display("post reset %0d: rvalid=%0d", r, flt_rvalid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_read_arbiter.md
FB_READ_ARBITER -- requirements
Module: fb_read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 15, frame-buffer address width (160x120 image).
REQ-002 Parameter DATA_WIDTH, 16, RGB565 pixel width.
REQ-003 Parameter MAX_WAIT, 8, filter wait cycles before forced grant; legal range 2..255.
REQ-004 clk  in  1  pixel clock (25 MHz); the block uses this one clock only.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 vga_req  in  1  display reader needs a pixel this cycle.
REQ-007 vga_addr  in  ADDR_WIDTH  display read address.
REQ-008 vga_rdata  out  DATA_WIDTH  display pixel, valid 1 cycle after vga_req.
REQ-009 flt_req  in  1  filter read request, held until granted.
REQ-010 flt_addr  in  ADDR_WIDTH  filter read address, stable while flt_req=1.
REQ-011 flt_gnt  out  1  combinational; filter request accepted this cycle.
REQ-012 flt_rvalid  out  1  registered; flt_rdata valid.
REQ-013 flt_rdata  out  DATA_WIDTH  filter pixel.
REQ-014 mem_en  out  1  frame-buffer read enable.
REQ-015 mem_addr  out  ADDR_WIDTH  frame-buffer read address.
REQ-016 mem_rdata  in  DATA_WIDTH  frame-buffer data, 1-cycle synchronous latency.
REQ-017 vga_stale_cnt  out  16  count of forced-grant cycles that served VGA stale cache data; saturating.

Function
REQ-018 One-entry VGA cache: cache_valid, cache_addr, cache_data.
REQ-019 VGA hit = vga_req & cache_valid & (vga_addr == cache_addr); VGA miss = vga_req & ~hit.
REQ-020 Port owner per cycle, priority order: FLT if flt_req & wait_cnt==MAX_WAIT; else VGA if miss; else FLT if flt_req; else NONE.
REQ-021 Owner VGA: mem_en=1, mem_addr=vga_addr, cache_addr<=vga_addr, cache_valid<=1; cache_data<=mem_rdata on the following edge.
REQ-022 Owner FLT: mem_en=1, mem_addr=flt_addr, flt_gnt=1; flt_rvalid=1 and flt_rdata=mem_rdata in the next cycle.
REQ-023 Owner NONE: mem_en=0, mem_addr holds previous value.
REQ-024 vga_rdata in cycle N+1 = mem_rdata if VGA owned the port in N; else cache_data (hit, or forced-grant stale).
REQ-025 Hit in cycle N+1 on an address missed in N returns the data captured at end of N+1 (no bypass error).
REQ-026 Forced grant while VGA misses: VGA served cache_data, cache not updated, vga_stale_cnt +1 (saturates at 16'hFFFF).
REQ-027 wait_cnt: +1 each cycle flt_req=1 and flt_gnt=0, saturates at MAX_WAIT; clears to 0 on flt_gnt or flt_req=0.
REQ-028 vga_req=0 for one cycle clears cache_valid (first pixel of each line always reads memory).
REQ-029 Back-to-back filter grants permitted every cycle; flt_rvalid pulses once per grant.
REQ-030 flt_req dropping without grant is legal; no read is issued.

Reset
REQ-031 On reset low, immediately: flt_rvalid=0, flt_rdata=0, vga_rdata=0, mem_en=0, mem_addr=0, vga_stale_cnt=0, cache_valid=0, cache_addr=0, cache_data=0, wait_cnt=0.
REQ-032 Reset asserted mid-transaction drops the in-flight read; no flt_rvalid follows reset release.
REQ-033 flt_gnt is 0 while reset is low.

Structure
REQ-034 Package cam_arb_pkg holds the owner enum (OWN_NONE, OWN_VGA, OWN_FLT) and PIXEL_W=16.
REQ-035 Sub-module fb_read_cache holds the one-entry cache, hit compare, and line-end invalidate; the arbiter top holds the owner decode, wait_cnt, and stats.

Verification
REQ-036 vga_req=1, addr sequence 5,5,6,6 with flt_req=0 -> mem_en pattern 1,0,1,0; vga_rdata = mem[5],mem[5],mem[6],mem[6].
REQ-037 Same VGA sequence with flt_req=1, flt_addr=100 -> flt_gnt in the hit cycles 2 and 4; flt_rvalid one cycle later with mem[100].
REQ-038 VGA misses every cycle (addr 0,1,2,...), flt_req=1, MAX_WAIT=8 -> flt_gnt in cycle 9; vga_rdata that cycle = previous cache_data; vga_stale_cnt=1.
REQ-039 Hit, then vga_req=0 for 1 cycle, then same addr -> memory re-read (mem_en=1); no hit.
REQ-040 Reset low during an outstanding filter read -> flt_rvalid never asserts; all outputs 0 asynchronously.
REQ-041 Saturation: force 65536 stale events -> vga_stale_cnt stays 16'hFFFF.
